// File: rtl/div_unit.sv
// Iterative RV32M divide unit: radix-2 restoring divider for DIV/DIVU/REM/REMU with a one-cycle write-back pulse.
// Optional `DIV_EARLY_OUT_EN skips the iteration phase for divide-by-zero, signed overflow and divisor > dividend.
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] writ_data,
   output logic            write_reg_enable
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [5:0]      cnt_q, cnt_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            spec_q, spec_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   logic            is_signed, a_neg, b_neg;
   logic            div_zero, sovf, accept, early_out;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   rem_sh, trial;
   logic [XLEN-1:0] q_fix, r_fix, result;

   // Issue-time decode of the operands presented on the register-file ports
   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & rs1_data[XLEN-1];
      b_neg     = is_signed & rs2_data[XLEN-1];
      a_mag     = a_neg ? -rs1_data : rs1_data;
      b_mag     = b_neg ? -rs2_data : rs2_data;
      div_zero  = (rs2_data == '0);
      sovf      = is_signed & (rs1_data == MIN_NEG) & (rs2_data == '1);
      accept    = start & ((state_q == S_IDLE) | (state_q == S_DONE));
`ifdef DIV_EARLY_OUT_EN
      early_out = div_zero | sovf | (b_mag > a_mag);
`else
      early_out = 1'b0;
`endif
   end

   always_comb begin
      rem_sh = {rem_q, quo_q[XLEN-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      q_fix  = qneg_q ? -quo_q : quo_q;
      r_fix  = rneg_q ? -rem_q : rem_q;
      result = op_q[1] ? r_fix : q_fix;
   end

   // Special cases preload the final quotient/remainder and freeze them through CALC
   always_comb begin
      op_d      = op_q;
      rd_d      = rd_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      spec_d    = spec_q;
      rd_addr_d = rd_addr_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               op_d   = op;
               rd_d   = rd_in;
               dvs_d  = b_mag;
               cnt_d  = '0;
               spec_d = div_zero | sovf;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               if (div_zero) begin
                  quo_d  = '1;
                  rem_d  = rs1_data;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end else if (sovf) begin
                  quo_d  = MIN_NEG;
                  rem_d  = '0;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
               end else if (early_out) begin
                  quo_d = '0;
                  rem_d = a_mag;
               end else begin
                  quo_d = a_mag;
                  rem_d = '0;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 6'd1;
            if (!spec_q) begin
               quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
               rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
            end
         end
         S_FIX: begin
            wdata_d   = result;
            rd_addr_d = rd_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = early_out ? S_FIX : S_CALC;
         S_CALC:  if (cnt_q == 6'd31) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = accept ? (early_out ? S_FIX : S_CALC) : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy             = (state_q == S_CALC) | (state_q == S_FIX);
      done             = (state_q == S_DONE);
      rd_addr          = rd_addr_q;
      writ_data        = wdata_q;
      write_reg_enable = done & (rd_addr_q != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         rd_q      <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         spec_q    <= 1'b0;
         rd_addr_q <= '0;
         wdata_q   <= '0;
      end else begin
         op_q      <= op_d;
         rd_q      <= rd_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         spec_q    <= spec_d;
         rd_addr_q <= rd_addr_d;
         wdata_q   <= wdata_d;
      end
   end

endmodule
